// File: rtl/approx_mul_arbiter.sv
// Round-robin front end sharing one external 8x8 approximate multiplier
// between N_REQ requesters, with an in-order credit-controlled result FIFO.
module approx_mul_arbiter #(
   parameter int N_REQ      = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req_valid,
   output logic [N_REQ-1:0]           req_ready,
   input  logic [8*N_REQ-1:0]         req_x,
   input  logic [8*N_REQ-1:0]         req_y,
   output logic [7:0]                 mul_x,
   output logic [7:0]                 mul_y,
   input  logic [15:0]                mul_z,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [15:0]                rsp_data,
   output logic [$clog2(N_REQ)-1:0]   rsp_id,
   output logic                       busy
);

   localparam int IDW = $clog2(N_REQ);
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int CW  = PW + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);
   localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ - 1);

   logic           iss_valid;
   logic [7:0]     iss_x;
   logic [7:0]     iss_y;
   logic [IDW-1:0] iss_id;
   logic [IDW-1:0] rr_ptr;

   logic [15:0]    mem_data [FIFO_DEPTH];
   logic [IDW-1:0] mem_id   [FIFO_DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [PW:0]    fifo_count;

   logic           grant_found;
   logic [IDW-1:0] grant_idx;
   logic [IDW-1:0] j;
   logic [CW:0]    credit_sum;
   logic           credit_ok;
   logic           accept;
   logic [7:0]     sel_x;
   logic [7:0]     sel_y;
   logic           push;
   logic           pop;

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      j           = '0;
      for (int k = 0; k < N_REQ; k++) begin
         j = IDW'((int'(rr_ptr) + k) % N_REQ);
         if (!grant_found && req_valid[j]) begin
            grant_found = 1'b1;
            grant_idx   = j;
         end
      end
   end

   // Credit uses only registered state so rsp_ready never reaches req_ready
   assign credit_sum = {1'b0, fifo_count} + {{CW{1'b0}}, iss_valid};
   assign credit_ok  = credit_sum < DEPTH_C;
   assign accept     = grant_found & credit_ok & ~rst;

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[grant_idx] = 1'b1;
   end

   always_comb begin
      sel_x = '0;
      sel_y = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (IDW'(i) == grant_idx) begin
            sel_x = req_x[8*i +: 8];
            sel_y = req_y[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         iss_valid <= 1'b0;
         iss_x     <= '0;
         iss_y     <= '0;
         iss_id    <= '0;
         rr_ptr    <= '0;
      end else begin
         iss_valid <= accept;
         if (accept) begin
            iss_x  <= sel_x;
            iss_y  <= sel_y;
            iss_id <= grant_idx;
            rr_ptr <= (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
         end
      end
   end

   assign mul_x = iss_x;
   assign mul_y = iss_y;

   assign push      = iss_valid;
   assign rsp_valid = (fifo_count != '0);
   assign pop       = rsp_valid & rsp_ready;

   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem_data[wr_ptr] <= mul_z;
         mem_id[wr_ptr]   <= iss_id;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   assign rsp_data = mem_data[rd_ptr];
   assign rsp_id   = mem_id[rd_ptr];
   assign busy     = iss_valid | rsp_valid;

endmodule
